// File: rtl/pb_press_classifier.sv
// Classifies debounced button presses into short / long / auto-repeat step pulses.
// Build option: define PB_AUTOREPEAT_EN to enable repeat pulses while long-held.
module pb_press_classifier #(
   parameter int LONG_CYCLES   = 1000,
   parameter int REPEAT_CYCLES = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic pressed_pulse,
   input  logic pressed_status,
   input  logic released_pulse,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic step_pulse,
   output logic busy
);

   localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef PB_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_LONG = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_short;
   logic             w_long;
   logic             w_rep;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_pulse <= 1'b0;
         step_pulse   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         short_press  <= w_short;
         long_press   <= w_long;
         repeat_pulse <= w_rep;
         step_pulse   <= w_short | w_long | w_rep;
         // rises with entry to HOLD, falls one cycle after return to IDLE
         busy         <= (r_state != S_IDLE) || (w_state_nxt != S_IDLE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_short     = 1'b0;
      w_long      = 1'b0;
      w_rep       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (pressed_pulse) begin
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (released_pulse) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_short     = 1'b1;
            end else if (!pressed_status) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LONG_LAST) begin
               w_state_nxt = S_LONG;
               w_cnt_nxt   = '0;
               w_long      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_LONG: begin
            if (released_pulse || !pressed_status) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
`ifdef PB_AUTOREPEAT_EN
            end else if (r_cnt == REP_LAST) begin
               w_cnt_nxt = '0;
               w_rep     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
`endif
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_pb_press_classifier.sv
// Directed bench for pb_press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_pb_press_classifier;

   logic clk = 1'b0;
   logic rst;
   logic pressed_pulse;
   logic pressed_status;
   logic released_pulse;
   logic short_press;
   logic long_press;
   logic repeat_pulse;
   logic step_pulse;
   logic busy;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef PB_AUTOREPEAT_EN
   localparam logic REP_EN = 1'b1;
`else
   localparam logic REP_EN = 1'b0;
`endif

   pb_press_classifier #(
      .LONG_CYCLES   (8),
      .REPEAT_CYCLES (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pressed_pulse  (pressed_pulse),
      .pressed_status (pressed_status),
      .released_pulse (released_pulse),
      .short_press    (short_press),
      .long_press     (long_press),
      .repeat_pulse   (repeat_pulse),
      .step_pulse     (step_pulse),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // vector order: {short, long, repeat, step, busy}
   task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] outs();
      return {short_press, long_press, repeat_pulse, step_pulse, busy};
   endfunction

   // pressed_pulse in cycle 0; masks give the cycles each output must be high
   task automatic run_scen(input int id, input int rel, input int stat_end, input int repress,
                           input logic [31:0] m_short, input logic [31:0] m_long,
                           input logic [31:0] m_rep, input logic [31:0] m_busy);
      logic [4:0] exp;
      logic       r;
      for (int c = 0; c < 32; c++) begin
         @(posedge clk);
         #1;
         pressed_pulse  = (c == 0) || (c == repress);
         pressed_status = (c <= stat_end);
         released_pulse = (c == rel);
         @(negedge clk);
         r   = m_rep[c] & REP_EN;
         exp = {m_short[c], m_long[c], r, m_short[c] | m_long[c] | r, m_busy[c]};
         chk($sformatf("scen%0d c%0d", id, c), outs(), exp);
      end
   endtask

   initial begin
      rst            = 1'b1;
      pressed_pulse  = 1'b0;
      pressed_status = 1'b0;
      released_pulse = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", outs(), 5'b00000);
      rst = 1'b0;
      @(negedge clk);
      chk("after_reset", outs(), 5'b00000);

      // short tap
      run_scen(1, 3, 3, -1, 32'h10, 32'h0, 32'h0, 32'h1E);
      // long hold with repeats, release on a repeat threshold cycle
      run_scen(2, 20, 20, -1, 32'h0, 32'h200, 32'h22000, 32'h3FFFFE);
      // release exactly on the long threshold cycle
      run_scen(3, 8, 8, -1, 32'h200, 32'h0, 32'h0, 32'h3FE);
      // status never rises
      run_scen(4, -1, -1, -1, 32'h0, 32'h0, 32'h0, 32'h6);
      // second pressed_pulse in HOLD must not restart the count
      run_scen(5, 12, 12, 5, 32'h0, 32'h200, 32'h0, 32'h3FFE);
      // status drop while in LONG
      run_scen(6, -1, 10, -1, 32'h0, 32'h200, 32'h0, 32'h1FFE);
      // status drop while in HOLD
      run_scen(7, -1, 4, -1, 32'h0, 32'h0, 32'h0, 32'h7E);

      // asynchronous reset in the middle of LONG
      for (int c = 0; c < 14; c++) begin
         @(posedge clk);
         #1;
         pressed_pulse  = (c == 0);
         pressed_status = 1'b1;
         released_pulse = 1'b0;
      end
      chk("pre_rst_busy", {4'b0000, busy}, 5'b00001);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", outs(), 5'b00000);
      repeat (2) @(negedge clk);
      chk("rst_held", outs(), 5'b00000);
      rst = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #1;
         pressed_status = 1'b1;
         released_pulse = (c == 5);
         @(negedge clk);
         chk($sformatf("post_rst c%0d", c), outs(), 5'b00000);
      end
      @(posedge clk);
      #1;
      pressed_status = 1'b0;
      released_pulse = 1'b0;
      repeat (2) @(negedge clk);

      // normal operation resumes after reset
      run_scen(8, 3, 3, -1, 32'h10, 32'h0, 32'h0, 32'h1E);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
